// File: rtl/btn_step_gen_pkg.sv
// btn_step_gen_pkg: shared FSM state, channel indices and counter width helper
package btn_step_gen_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam int BTN_MIN = 0;
  localparam int BTN_HOUR = 1;
  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/btn_step_gen_if.sv
// btn_step_gen_if: raw button levels in, debounced levels and step pulses out
interface btn_step_gen_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] pressed;
  logic [N_BTN-1:0] step;
  modport master (output btn_raw, input pressed, input step);
  modport slave (input btn_raw, output pressed, output step);
endinterface

// File: rtl/btn_step_gen_channel.sv
// btn_channel: synchronizer, debounce and step FSM for one button; auto-repeat enabled by macro BTN_AUTOREPEAT_EN
module btn_channel
  import btn_step_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pressed,
  output logic step
);
  localparam int W = cntWidth(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  logic flip;
  state_t state;
  assign flip = (sync[1] != pressed) && (cnt == W'(DEBOUNCE_CYCLES - 1));
  // pressed flips on the edge where the DEBOUNCE_CYCLES-th consecutive mismatching sample arrives
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] == pressed || flip) ? '0 : (cnt == '1 ? cnt : cnt + W'(1));
      pressed <= pressed ^ flip;
    end
`ifdef BTN_AUTOREPEAT_EN
  logic [W-1:0] timer;
  logic hit;
  assign hit = timer == (state == HOLD ? W'(HOLD_CYCLES - 1) : W'(REPEAT_CYCLES - 1));
  // step on accepted press, again after HOLD_CYCLES, then every REPEAT_CYCLES; release aborts silently
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      step <= 1'b0;
    end else if (flip && pressed) begin
      state <= IDLE;
      timer <= '0;
      step <= 1'b0;
    end else if (state == IDLE) begin
      state <= flip ? HOLD : IDLE;
      timer <= '0;
      step <= flip;
    end else begin
      state <= hit ? REPEAT : state;
      timer <= hit ? '0 : (timer == '1 ? timer : timer + W'(1));
      step <= hit;
    end
`else
  // one step per accepted press; release returns to IDLE without a pulse
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      step <= 1'b0;
    end else begin
      state <= flip ? (pressed ? IDLE : HOLD) : state;
      step <= flip && !pressed;
    end
`endif
endmodule

// File: rtl/btn_step_gen.sv
// btn_step_gen: N_BTN independent debounced step generators; auto-repeat enabled by macro BTN_AUTOREPEAT_EN
module btn_step_gen
  import btn_step_gen_pkg::*;
#(
  parameter int N_BTN = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input logic clk,
  input logic reset,
  btn_step_gen_if.slave bus
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(bus.btn_raw[i]),
      .pressed(bus.pressed[i]),
      .step(bus.step[i])
    );
  end
endmodule

// File: doc/btn_step_gen.md
BTN_STEP_GEN -- requirements
Module: btn_step_gen

Interface
REQ-001 SHALL have parameter N_BTN, default 2, number of independent button channels (bit 0 = minute, bit 1 = hour).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable samples needed to accept a level change.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000, debounced-press duration before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_CYCLES, default 20_000_000, auto-repeat period.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port btn_raw, input, N_BTN, asynchronous bouncing pushbutton levels, 1 = pressed.
REQ-008 SHALL have port pressed, output, N_BTN, debounced button level.
REQ-009 SHALL have port step, output, N_BTN, one-cycle increment pulse per channel, the producer side of the hrup/minup pulse interface.

Function
REQ-010 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other logic.
REQ-011 SHALL, per channel, count cycles where the synchronized level differs from pressed, clearing the count whenever they match; pressed SHALL toggle when the count reaches DEBOUNCE_CYCLES.
REQ-012 SHALL, for raw input held stable from cycle 0, update pressed exactly at edge 2+DEBOUNCE_CYCLES; shorter glitches SHALL produce no change.
REQ-013 SHALL run a per-channel FSM with states IDLE, HOLD, REPEAT.
REQ-014 IDLE: on pressed rising, assert step for one cycle, coincident with pressed going high, and enter HOLD with timer cleared.
REQ-015 HOLD: count while pressed; at HOLD_CYCLES, pulse step, clear timer, enter REPEAT.
REQ-016 REPEAT: pulse step every REPEAT_CYCLES while pressed.
REQ-017 Any state: pressed falling returns the channel to IDLE in the same cycle with no step pulse; release SHALL never generate step.
REQ-018 Channels SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses with no priority or lockout.
REQ-019 step SHALL be high for exactly one cycle per event, never two consecutive cycles.
REQ-020 Timers SHALL saturate, never wrap; width = clog2 of the largest of the three parameters plus 1.

Reset
REQ-021 On reset high at a clock edge: synchronizers, debounce counters and timers SHALL be 0, pressed = 0, step = 0, all FSMs = IDLE.
REQ-022 Reset mid-press SHALL abort any repeat; a button still held after reset release SHALL be accepted as a fresh press after the full debounce, giving one step.

Configuration
REQ-023 Macro BTN_AUTOREPEAT_EN defined: HOLD/REPEAT behaviour as above.
REQ-024 Macro BTN_AUTOREPEAT_EN undefined: FSM reduces to IDLE/HOLD with no timer, exactly one step per press; HOLD_CYCLES and REPEAT_CYCLES SHALL be ignored.

Structure
REQ-025 Shared package SHALL hold the FSM state enum (IDLE, HOLD, REPEAT) and the channel index constants BTN_MIN = 0 and BTN_HOUR = 1.
REQ-026 One sub-module btn_channel SHALL implement synchronizer, debounce and FSM for one bit; btn_step_gen SHALL instantiate it N_BTN times.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-027 btn_raw[0] rises at cycle 0 and holds -> pressed[0] and step[0] high at edge 6; step[0] low at edge 7.
REQ-028 btn_raw[0] bounces 1,0,1,0 with 2-cycle pulses, then holds high -> exactly one step[0], 6 edges after the final rise.
REQ-029 Hold btn_raw[1] for 60 cycles after acceptance -> step[1] pulses at offsets 0, 20, 28, 36, 44, 52; after release, none.
REQ-030 Both bits rise in the same cycle -> step = 2'b11 in the same cycle.
REQ-031 Reset asserted during REPEAT with button held -> outputs 0 next edge; after deassert, step after 6 edges, then next at +20.
REQ-032 Build without BTN_AUTOREPEAT_EN, hold 100 cycles -> exactly one step pulse.
